// File: rtl/vr_tooth_qualifier_pkg.sv
// Shared types and default constants for the crank tooth qualifier.
package vr_tooth_qualifier_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRST = 2'd1,
        ST_RUN   = 2'd2
    } vr_state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 8;
    localparam int DEF_MIN_FRAC_SHIFT  = 2;
    localparam int DEF_STALL_CYCLES    = 400000;
    localparam int DEF_PERIOD_W        = 32;

endpackage

// File: rtl/vr_tooth_qualifier_level_debouncer.sv
// Level debouncer: the filtered level follows din once din has disagreed with it
// for DEBOUNCE_CYCLES+1 consecutive samples; rise strobes on each filtered 0->1.
module level_debouncer
    import vr_tooth_qualifier_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam logic [7:0] CNT_TH = 8'(DEBOUNCE_CYCLES);

    logic [7:0] r_cnt;
    logic       r_level;
    logic       r_rise;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            if (din == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_TH) begin
                r_level <= din;
                r_cnt   <= '0;
                r_rise  <= din;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;

endmodule

// File: rtl/vr_tooth_qualifier.sv
// Crank tooth qualifier: debounces vr_sync, rejects early edges against the last
// accepted period, measures tooth period and flags engine stall.
module vr_tooth_qualifier
    import vr_tooth_qualifier_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int MIN_FRAC_SHIFT  = DEF_MIN_FRAC_SHIFT,
    parameter int STALL_CYCLES    = DEF_STALL_CYCLES,
    parameter int PERIOD_W        = DEF_PERIOD_W
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                vr_sync,
    output logic                tooth_pulse,
    output logic [PERIOD_W-1:0] tooth_period,
    output logic                period_valid,
    output logic                stall,
    output logic [7:0]          reject_cnt
);

    localparam logic [PERIOD_W-1:0] STALL_TH = PERIOD_W'(STALL_CYCLES);

    logic                w_level;
    logic                w_rise;
    logic                w_cand;
    logic                w_accept;
    logic [PERIOD_W-1:0] w_min;
    logic [PERIOD_W-1:0] w_cnt_inc;

    vr_state_e           r_state;
    logic [PERIOD_W-1:0] r_cnt;
    logic [PERIOD_W-1:0] r_period;
    logic                r_pulse;
    logic                r_pv;
    logic                r_stall;
    logic [7:0]          r_rej;

    level_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (vr_sync),
        .level   (w_level),
        .rise    (w_rise)
    );

    assign w_cand    = w_rise & w_level;
    assign w_min     = r_period >> MIN_FRAC_SHIFT;
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
    // r_cnt is the distance to the last pulse as seen by the pulse this edge would make
    assign w_accept  = w_cand && ((r_state == ST_FIRST) ||
                                  (r_state == ST_RUN && r_cnt >= w_min));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_period <= '0;
            r_pulse  <= 1'b0;
            r_pv     <= 1'b0;
            r_stall  <= 1'b1;
            r_rej    <= '0;
        end else begin
            r_pulse <= 1'b0;
            r_pv    <= 1'b0;
            r_cnt   <= w_cnt_inc;
            case (r_state)
                ST_IDLE: begin
                    if (w_cand) begin
                        r_pulse <= 1'b1;
                        r_stall <= 1'b0;
                        r_cnt   <= PERIOD_W'(1);
                        r_state <= ST_FIRST;
                    end
                end
                ST_FIRST, ST_RUN: begin
                    if (w_accept) begin
                        r_pulse  <= 1'b1;
                        r_pv     <= 1'b1;
                        r_period <= r_cnt;
                        r_cnt    <= PERIOD_W'(1);
                        r_state  <= ST_RUN;
                    end else begin
                        if (w_cand && r_rej != 8'hFF)
                            r_rej <= r_rej + 8'd1;
                        if (r_cnt >= STALL_TH) begin
                            r_stall  <= 1'b1;
                            r_period <= '0;
                            r_state  <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign tooth_pulse  = r_pulse;
    assign tooth_period = r_period;
    assign period_valid = r_pv;
    assign stall        = r_stall;
    assign reject_cnt   = r_rej;

endmodule
